// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: passes ALU results through, or issues one held
// memory request and returns its result. Optional watchdog enabled by MEM_TIMEOUT_EN.
module mem_access_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] instruction,
    input  logic [15:0] alu_res,
    input  logic [15:0] store_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic        out_valid,
    output logic [15:0] out_data,
    output logic        out_is_load,
    output logic        err
);

    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 32'd1);

    function automatic logic is_mem_op(input logic [4:0] op);
        case (op)
            5'b10011, 5'b10010, 5'b11011, 5'b11010: is_mem_op = 1'b1;
            default:                                is_mem_op = 1'b0;
        endcase
    endfunction

    function automatic logic is_write_op(input logic [4:0] op);
        case (op)
            5'b11011, 5'b11010: is_write_op = 1'b1;
            default:            is_write_op = 1'b0;
        endcase
    endfunction

    state_t      state_r, state_nxt_s;
    logic        mem_req_r, mem_we_r, out_valid_r, out_is_load_r, err_r;
    logic [15:0] mem_addr_r, mem_wdata_r, out_data_r;
    logic        mem_req_nxt_s, mem_we_nxt_s, out_valid_nxt_s, out_is_load_nxt_s, err_nxt_s;
    logic [15:0] mem_addr_nxt_s, mem_wdata_nxt_s, out_data_nxt_s;
    logic        accept_s, accept_mem_s, ack_s, timeout_s;
    logic        unused_cfg_s;

    assign accept_s     = in_valid && (state_r == IDLE);
    assign accept_mem_s = accept_s && is_mem_op(instruction[15:11]);
    assign ack_s        = (state_r == WAIT) && mem_ack;
    assign unused_cfg_s = ^{instruction[10:0], TIMEOUT_LAST};

`ifdef MEM_TIMEOUT_EN
    logic [15:0] tmo_cnt_r;
    assign timeout_s = (state_r == WAIT) && !mem_ack && (tmo_cnt_r == TIMEOUT_LAST);

    // Watchdog: cleared on WAIT entry, counts WAIT cycles without acknowledge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_r <= 16'h0000;
        end else if (accept_mem_s) begin
            tmo_cnt_r <= 16'h0000;
        end else if ((state_r == WAIT) && !mem_ack) begin
            tmo_cnt_r <= tmo_cnt_r + 16'h0001;
        end else begin
            tmo_cnt_r <= tmo_cnt_r;
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_mem_s) state_nxt_s = WAIT;
                else              state_nxt_s = IDLE;
            end
            WAIT: begin
                if (ack_s || timeout_s) state_nxt_s = IDLE;
                else                    state_nxt_s = WAIT;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Next values of the registered outputs; request fields hold through WAIT
    always_comb begin
        mem_req_nxt_s     = mem_req_r;
        mem_we_nxt_s      = mem_we_r;
        mem_addr_nxt_s    = mem_addr_r;
        mem_wdata_nxt_s   = mem_wdata_r;
        out_valid_nxt_s   = 1'b0;
        out_data_nxt_s    = out_data_r;
        out_is_load_nxt_s = out_is_load_r;
        err_nxt_s         = err_r;
        case (state_r)
            IDLE: begin
                if (accept_mem_s) begin
                    mem_req_nxt_s   = 1'b1;
                    mem_we_nxt_s    = is_write_op(instruction[15:11]);
                    mem_addr_nxt_s  = alu_res;
                    mem_wdata_nxt_s = store_data;
                end else if (accept_s) begin
                    out_valid_nxt_s   = 1'b1;
                    out_data_nxt_s    = alu_res;
                    out_is_load_nxt_s = 1'b0;
                end else begin
                    out_valid_nxt_s = 1'b0;
                end
            end
            WAIT: begin
                if (ack_s) begin
                    mem_req_nxt_s     = 1'b0;
                    out_valid_nxt_s   = 1'b1;
                    out_data_nxt_s    = mem_we_r ? mem_addr_r : mem_rdata;
                    out_is_load_nxt_s = !mem_we_r;
                end else if (timeout_s) begin
                    mem_req_nxt_s     = 1'b0;
                    out_valid_nxt_s   = 1'b1;
                    out_data_nxt_s    = 16'h0000;
                    out_is_load_nxt_s = 1'b0;
                    err_nxt_s         = 1'b1;
                end else begin
                    out_valid_nxt_s = 1'b0;
                end
            end
            default: begin
                mem_req_nxt_s   = 1'b0;
                out_valid_nxt_s = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= IDLE;
            mem_req_r     <= 1'b0;
            mem_we_r      <= 1'b0;
            mem_addr_r    <= 16'h0000;
            mem_wdata_r   <= 16'h0000;
            out_valid_r   <= 1'b0;
            out_data_r    <= 16'h0000;
            out_is_load_r <= 1'b0;
            err_r         <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            mem_req_r     <= mem_req_nxt_s;
            mem_we_r      <= mem_we_nxt_s;
            mem_addr_r    <= mem_addr_nxt_s;
            mem_wdata_r   <= mem_wdata_nxt_s;
            out_valid_r   <= out_valid_nxt_s;
            out_data_r    <= out_data_nxt_s;
            out_is_load_r <= out_is_load_nxt_s;
            err_r         <= err_nxt_s;
        end
    end

    assign in_ready    = (state_r == IDLE);
    assign mem_req     = mem_req_r;
    assign mem_we      = mem_we_r;
    assign mem_addr    = mem_addr_r;
    assign mem_wdata   = mem_wdata_r;
    assign out_valid   = out_valid_r;
    assign out_data    = out_data_r;
    assign out_is_load = out_is_load_r;
    assign err         = err_r;

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 TIMEOUT_CYCLES, 255, WAIT cycles without mem_ack before abort (used only with MEM_TIMEOUT_EN); legal range 1..65535.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  upstream result presented.
REQ-005 in_ready  output  1  stage can accept; transfer when in_valid&&in_ready at a rising edge.
REQ-006 instruction  input  16  instruction word of the presented result.
REQ-007 alu_res  input  16  ALU result: pass-through value or memory address.
REQ-008 store_data  input  16  write data for SW/SW_SP.
REQ-009 mem_req  output  1  memory request, held until acknowledged.
REQ-010 mem_we  output  1  1=write, 0=read; valid while mem_req.
REQ-011 mem_addr  output  16  memory address; valid while mem_req.
REQ-012 mem_wdata  output  16  write data; valid while mem_req&&mem_we.
REQ-013 mem_rdata  input  16  read data; sampled in the mem_ack cycle.
REQ-014 mem_ack  input  1  memory completion; one-cycle pulse.
REQ-015 out_valid  output  1  one-cycle pulse: out_data valid for writeback.
REQ-016 out_data  output  16  writeback value.
REQ-017 out_is_load  output  1  qualifies out_valid: result came from memory read.
REQ-018 err  output  1  sticky timeout flag.

Function
REQ-019 Decode instruction[15:11]: 10011 LW, 10010 LW_SP (read); 11011 SW, 11010 SW_SP (write); all other codes non-memory.
REQ-020 States SHALL be IDLE and WAIT; in_ready=1 exactly in IDLE.
REQ-021 Non-memory accept in IDLE: next cycle out_valid=1, out_data=alu_res, out_is_load=0; stay IDLE; back-to-back accepts give one result per cycle.
REQ-022 Memory accept in IDLE: next cycle enter WAIT with mem_req=1, mem_addr=alu_res, mem_we=1 for write else 0, mem_wdata=store_data; out_valid=0.
REQ-023 In WAIT, mem_req/mem_we/mem_addr/mem_wdata SHALL hold stable until the edge sampling mem_ack=1.
REQ-024 On that edge: mem_req=0, state IDLE, out_valid=1; read gives out_data=mem_rdata, out_is_load=1; write gives out_data=alu_res latched address, out_is_load=0.
REQ-025 Minimum memory latency: accept edge to out_valid = 2 edges; in_ready returns high with out_valid.
REQ-026 mem_ack while mem_req=0 SHALL be ignored; in_valid in WAIT SHALL be ignored (no accept).
REQ-027 out_valid never high two cycles for one accepted item; out_data holds last value when out_valid=0.

Reset
REQ-028 rst=1 SHALL immediately force IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, out_valid=0, out_data=0, out_is_load=0, err=0, timeout counter=0; in_ready=1 after release.
REQ-029 Reset during WAIT SHALL abandon the access with no out_valid; a later mem_ack SHALL be ignored.

Configuration
REQ-030 MEM_TIMEOUT_EN defined: 16-bit counter clears on WAIT entry, increments each WAIT cycle without mem_ack; at TIMEOUT_CYCLES: mem_req=0, IDLE, out_valid=1, out_data=0x0000, out_is_load=0, err=1 sticky until rst; mem_ack in that same cycle wins (normal completion).
REQ-031 MEM_TIMEOUT_EN undefined: no counter, WAIT persists until mem_ack, err tied 0.

Verification
REQ-032 ADDU word, alu_res=0x1234, in_valid 1 cycle -> next cycle out_valid=1, out_data=0x1234, out_is_load=0, mem_req stays 0.
REQ-033 LW alu_res=0x8000, mem_ack after 3 WAIT cycles, mem_rdata=0xBEEF -> mem_req/mem_addr=0x8000/mem_we=0 stable 3 cycles; out_valid with out_data=0xBEEF, out_is_load=1.
REQ-034 SW_SP alu_res=0x0040, store_data=0x5A5A, immediate ack -> mem_we=1, mem_wdata=0x5A5A, out_valid 2 edges after accept, out_data=0x0040.
REQ-035 Three non-memory words back-to-back (0x0001,0x0002,0x0003) -> three consecutive out_valid pulses in order, in_ready constantly 1.
REQ-036 LW then rst asserted during WAIT, later mem_ack -> all outputs 0 at once, no out_valid, in_ready=1 after release.
REQ-037 MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, LW never acked -> after 4 WAIT cycles mem_req=0, out_valid=1, out_data=0x0000, err=1 persisting until rst.
